// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: FSM states, op encodings
// and default widths.
package shift_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step (1 or 4 bit positions) for SLL/SRL/SRA.
// The reserved op passes the value through unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       op,
  input  logic             step4,
  output logic [WIDTH-1:0] next_value
);

  logic [2:0] sh;

  // Select the step distance and apply it according to the latched op
  always_comb begin
    sh = step4 ? 3'd4 : 3'd1;
    case (op)
      OP_SLL:  next_value = value << sh;
      OP_SRL:  next_value = value >> sh;
      OP_SRA:  next_value = $unsigned($signed(value) >>> sh);
      default: next_value = value;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: sequences shift_step until the shift amount
// is consumed, stalls the pipeline meanwhile and pulses done with the result.
// Optional feature macro: SHIFT_SEQ_FAST4_EN (4-bit steps while count >= 4).
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               stall
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step_value;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] step;
  logic [1:0]         op_q;
  logic               step4;
  logic               can_accept;
  logic               accept;
  logic               quick;
  logic               last_step;

  // A request is taken only when the unit is free and not being killed;
  // zero-amount and reserved requests complete without entering SHIFT.
  assign can_accept = (state == IDLE) || (state == DONE);
  assign accept     = start && can_accept && !flush;
  assign quick      = (shamt == '0) || (op == OP_RSVD);

`ifdef SHIFT_SEQ_FAST4_EN
  assign step4 = (count >= SHAMT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  assign step      = step4 ? SHAMT_W'(4) : SHAMT_W'(1);
  assign last_step = (count == step);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (work),
    .op         (op_q),
    .step4      (step4),
    .next_value (step_value)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) state_nxt = quick ? DONE : SHIFT;
          else        state_nxt = IDLE;
        end
        SHIFT:   state_nxt = last_step ? DONE : SHIFT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs; stall must assert in the request cycle itself, before busy rises
  always_comb begin
    busy   = (state == SHIFT);
    done   = (state == DONE);
    result = result_q;
    stall  = (start && can_accept && !quick && !flush) || busy;
  end

  // Working register, count and completed result. result_q only changes when
  // an operation completes, so a flush leaves the last good value visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      work     <= '0;
      count    <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
    end else if (accept) begin
      work  <= operand;
      op_q  <= op;
      count <= shamt;
      if (quick) result_q <= operand;
    end else if (busy && !flush) begin
      work  <= step_value;
      count <= count - step;
      if (last_step) result_q <= step_value;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer. Expected results come
// from plain shift arithmetic; expected timing from the latency formula.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] last_res;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input int n);
    case (o)
      2'b00:   return x << n;
      2'b01:   return x >> n;
      2'b10:   return $unsigned($signed(x) >>> n);
      default: return x;
    endcase
  endfunction

  // Cycle index of the done pulse, counting the start cycle as 0
  function automatic int lat(input logic [1:0] o, input int n);
    if (n == 0 || o == 2'b11) return 1;
`ifdef SHIFT_SEQ_FAST4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Issue a request in the current cycle and follow it to its done cycle.
  // Returns positioned inside the done cycle so a follow-up can go back-to-back.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [4:0] n,
                       input int ignore_at);
    int          l;
    logic [31:0] e;
    l = lat(o, int'(n));
    e = model(o, x, int'(n));
    op = o; operand = x; shamt = n; start = 1'b1; flush = 1'b0;
    #1 chk("stall_c0", {31'b0, stall}, {31'b0, (n != 0 && o != 2'b11)});
    for (int c = 1; c <= l; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == ignore_at) begin
        start = 1'b1; op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
      end
      #1;
      chk("busy",  {31'b0, busy},  {31'b0, c < l});
      chk("done",  {31'b0, done},  {31'b0, c == l});
      chk("stall", {31'b0, stall}, {31'b0, c < l});
    end
    chk("result", result, e);
    last_res = e;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("idle_busy",   {31'b0, busy},  32'd0);
    chk("idle_done",   {31'b0, done},  32'd0);
    chk("idle_stall",  {31'b0, stall}, 32'd0);
    chk("idle_result", result, last_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; operand = '0; shamt = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",   {31'b0, busy},  32'd0);
    chk("rst_done",   {31'b0, done},  32'd0);
    chk("rst_result", result,         32'd0);
    chk("rst_stall",  {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();

    // Directed cases
    @(negedge clk); issue(2'b00, 32'h0000_000F, 5'd4, 0);
    idle_cycle();
    @(negedge clk); issue(2'b10, 32'h8000_0000, 5'd31, 0);
    idle_cycle();
    @(negedge clk); issue(2'b01, 32'h8000_0000, 5'd31, 0);
    idle_cycle();
    @(negedge clk); issue(2'b00, 32'h0000_000C, 5'd0, 0);
    idle_cycle();
    @(negedge clk); issue(2'b11, 32'h0000_000C, 5'd7, 0);
    idle_cycle();
    @(negedge clk); issue(2'b01, 32'h0000_00F0, 5'd4, 0);
    issue(2'b00, 32'h0000_0001, 5'd1, 0);
    idle_cycle();
    @(negedge clk); issue(2'b10, 32'hF000_1234, 5'd12, 3);
    idle_cycle();
    @(negedge clk); issue(2'b00, 32'h0000_0001, 5'd9, 0);
    idle_cycle();

    // Flush in cycle 3 of SLL by 8, with a start in the same cycle that must be dropped
    @(negedge clk);
    op = 2'b00; operand = 32'h0000_00FF; shamt = 5'd8; start = 1'b1;
    #1 chk("fl_stall_c0", {31'b0, stall}, 32'd1);
    @(negedge clk); start = 1'b0; #1 chk("fl_busy1", {31'b0, busy}, 32'd1);
    @(negedge clk); #1 chk("fl_busy2", {31'b0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'b00; operand = 32'h5; shamt = 5'd0;
    #1 chk("fl_busy3", {31'b0, busy}, 32'd1);
    @(negedge clk); flush = 1'b0; start = 1'b0;
    #1;
    chk("fl_busy4",   {31'b0, busy}, 32'd0);
    chk("fl_done4",   {31'b0, done}, 32'd0);
    chk("fl_result4", result, last_res);
    idle_cycle();
    idle_cycle();

    // Reset in the middle of a shift discards it and clears the result
    @(negedge clk);
    op = 2'b10; operand = 32'h8765_4321; shamt = 5'd20; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("mrst_busy",   {31'b0, busy},  32'd0);
    chk("mrst_done",   {31'b0, done},  32'd0);
    chk("mrst_result", result,         32'd0);
    chk("mrst_stall",  {31'b0, stall}, 32'd0);
    last_res = '0;
    idle_cycle();

    // Randomized requests, mixing back-to-back issue, idle gaps and ignored starts
    @(negedge clk);
    for (int k = 0; k < 80; k++) begin
      logic [1:0]  o;
      logic [31:0] x;
      logic [4:0]  n;
      int          ign;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      n = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ign = (lat(o, int'(n)) > 3 && $urandom_range(0, 2) == 0) ? 2 : 0;
      issue(o, x, n, ign);
      if ($urandom_range(0, 1) == 1) begin
        idle_cycle();
        @(negedge clk);
      end
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the pipeline's EX stage. It accepts one shift request (SLL/SRL/SRA) from the decode/EX boundary and sequences a one-bit-per-cycle shift-step datapath until the shift amount is exhausted. It stalls the pipeline while the shift runs and returns the result with a one-cycle `done` pulse. It replaces a full barrel shifter with an iterative unit plus this sequencer.

## Interface
- `WIDTH`, default 32: operand/result width.
- `SHAMT_W`, default 5: shift-amount width. `2**SHAMT_W` must equal `WIDTH`.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request strobe, sampled on the clock edge.
- `op`, input, 2: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- `operand`, input, WIDTH: value to shift, sampled with `start`.
- `shamt`, input, SHAMT_W: shift amount, sampled with `start`.
- `flush`, input, 1: abort the request in progress (branch/exception kill).
- `busy`, output, 1: high while in SHIFT.
- `done`, output, 1: one-cycle pulse; `result` is valid in that cycle.
- `result`, output, WIDTH: shifted value; held until the next accepted `start`.
- `stall`, output, 1: pipeline hold request, combinational.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Reset:** state=IDLE; `busy`=0, `done`=0, `result`=0, internal count=0.
- **Accepting `start` in IDLE or DONE:**
  - Latch `operand` into the working register, and latch `op`.
  - Load count with `shamt`.
  - If `shamt`==0 or `op`==11, go to DONE with the working register unchanged. Otherwise go to SHIFT.
- **SHIFT:** each cycle applies one step and decrements count. When the post-step count is 0, go to DONE.
  - SLL: shift left, zero-fill.
  - SRL: shift right, zero-fill.
  - SRA: shift right, fill with the current MSB, so the operand's sign is preserved.
- **DONE:** `done`=1 and `result`=working register. Without a new `start`, go to IDLE next cycle. With `start`, accept it (back-to-back issue).
- **`start` while in SHIFT:** ignored. The pipeline is stalled, so this is a protocol error that does not corrupt state.
- **`flush`:** from any state, go to IDLE next edge with no `done` pulse. `result` keeps its last completed value. `flush` beats `start` in the same cycle.
- **`reset`:** beats `flush` and `start`. Reset during SHIFT discards the operation.
- **`stall`** = (`start` & (IDLE | DONE) & `shamt`!=0 & `op`!=11 & !`flush`) | `busy`.

## Timing
- `start` is sampled at edge 0.
- For `shamt`=N>0: SHIFT occupies cycles 1..N and `done` is high in cycle N+1. Total latency is N+1 cycles.
- For `shamt`=0 or `op`=11: `done` is high in cycle 1, with no stall.
- `busy` rises in cycle 1 and falls after cycle N. `stall` covers cycle 0 through cycle N.
- Back-to-back: a `start` in a DONE cycle gives the next request's cycle 1 on the following cycle, with no idle gap.

## Configuration
- **`SHIFT_SEQ_FAST4_EN` defined:** in SHIFT, when count ≥ 4, apply a 4-bit step and subtract 4. Otherwise apply a 1-bit step. Latency becomes floor(N/4) + (N mod 4) + 1 cycles, and `busy`/`stall` shrink accordingly.
- **Undefined:** 1-bit steps only, as described in Operation.

## Structure
- **Shared package `shift_pkg`:**
  - state enum (IDLE/SHIFT/DONE);
  - op encodings (`OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_RSVD`);
  - `WIDTH`/`SHAMT_W` defaults.
- **Sub-module `shift_step`:** combinational. Inputs are the working value, op and step size (1 or 4); output is the next value. The sequencer owns the FSM, count and registers.

## Test plan
- SLL, `operand`=0x0000_000F, `shamt`=4 → `done` in cycle 5, `result`=0x0000_00F0, `stall` high in cycles 0–4.
- SRA, `operand`=0x8000_0000, `shamt`=31 → `done` in cycle 32, `result`=0xFFFF_FFFF. The same request as SRL → `result`=0x0000_0001.
- `shamt`=0 SLL, `operand`=0xC → `done` in cycle 1, `result`=0xC, `stall` never high. An `op`=11 request behaves identically.
- `flush` in cycle 3 of SLL `shamt`=8 → IDLE in cycle 4, no `done`, `result` keeps its prior value. A `start` asserted together with `flush` is dropped.
- Back-to-back: SRL 0xF0 by 4, then `start` in its DONE cycle with SLL 0x1 by 1 → results 0x0F then 0x2, `done` pulses two cycles apart. A `start` pulsed during SHIFT is ignored.
- `reset` mid-SHIFT → next cycle has all outputs 0 and state IDLE. With `SHIFT_SEQ_FAST4_EN` defined, SLL by 9 → `done` in cycle 4.
